// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared FSM type and maximal-length tap table for lfsr_rng
package rng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REDUCE = 2'd2
  } rng_state_t;

  // Fibonacci feedback masks (bit i set = state[i] feeds the XOR), maximal length
  function automatic logic [31:0] max_taps(input int width);
    case (width)
      4:       max_taps = 32'h0000_000C;
      5:       max_taps = 32'h0000_0014;
      6:       max_taps = 32'h0000_0030;
      7:       max_taps = 32'h0000_0060;
      8:       max_taps = 32'h0000_00B8;
      9:       max_taps = 32'h0000_0110;
      10:      max_taps = 32'h0000_0240;
      11:      max_taps = 32'h0000_0500;
      12:      max_taps = 32'h0000_0829;
      13:      max_taps = 32'h0000_100D;
      14:      max_taps = 32'h0000_2015;
      15:      max_taps = 32'h0000_6000;
      16:      max_taps = 32'h0000_B400;
      17:      max_taps = 32'h0001_2000;
      18:      max_taps = 32'h0002_0400;
      19:      max_taps = 32'h0004_0023;
      20:      max_taps = 32'h0009_0000;
      21:      max_taps = 32'h0014_0000;
      22:      max_taps = 32'h0030_0000;
      23:      max_taps = 32'h0042_0000;
      24:      max_taps = 32'h00E1_0000;
      25:      max_taps = 32'h0120_0000;
      26:      max_taps = 32'h0200_0023;
      27:      max_taps = 32'h0400_0013;
      28:      max_taps = 32'h0900_0000;
      29:      max_taps = 32'h1400_0000;
      30:      max_taps = 32'h2000_0029;
      31:      max_taps = 32'h4800_0000;
      32:      max_taps = 32'h8020_0003;
      default: max_taps = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_rng_if.sv
// rtl/lfsr_rng_if.sv - sample request/response bundle for lfsr_rng
interface lfsr_rng_if #(
  parameter int WIDTH = 8
);
  logic             req;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] rnd;

  modport master (output req, input busy, input valid, input rnd);
  modport slave  (input req, output busy, output valid, output rnd);
endinterface

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Fibonacci LFSR register with reseed and all-zero recovery
module lfsr_core #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(100)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] state_next,
  output logic             shifting
);

  logic fb;

  // next state by priority: reseed, lockup recovery, shift, hold
  always_comb begin
    fb         = ^(state & TAPS);
    shifting   = 1'b0;
    state_next = state;
    if (seed_load) begin
      state_next = (seed_in == '0) ? SEED : seed_in;
    end else if (state == '0) begin
      state_next = SEED;
    end else if (enable) begin
      state_next = {state[WIDTH-2:0], fb};
      shifting   = 1'b1;
    end
  end

  // state register, seeded on reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= SEED;
    end else begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - sampled LFSR random source with range reduction
module lfsr_rng
  import rng_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(max_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(100),
  parameter int unsigned      SHIFTS   = 8,
  parameter int unsigned      OUT_MIN  = 0,
  parameter int unsigned      OUT_SPAN = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] lfsr,
  lfsr_rng_if.slave        bus
);

  localparam int unsigned     CW        = $clog2(SHIFTS + 1);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(SHIFTS - 1);
  localparam longint unsigned RANGE_TOP = longint'(OUT_MIN) + longint'(OUT_SPAN);
  localparam logic [WIDTH:0]  SPAN_X    = (WIDTH + 1)'(OUT_SPAN);
  localparam logic [WIDTH-1:0] SPAN_W   = WIDTH'(OUT_SPAN);
  localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(OUT_MIN);

  // refuse configurations that cannot work
  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_rng: WIDTH must be 4..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_rng: SEED must be nonzero");
  end
  if (SHIFTS < 1) begin : g_bad_shifts
    $error("lfsr_rng: SHIFTS must be at least 1");
  end
  if (OUT_SPAN != 0 && (RANGE_TOP - 1) >= (64'd1 << WIDTH)) begin : g_bad_range
    $error("lfsr_rng: OUT_MIN+OUT_SPAN-1 does not fit in WIDTH bits");
  end

  logic [WIDTH-1:0] lfsr_next;
  logic             shifting;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .state      (lfsr),
    .state_next (lfsr_next),
    .shifting   (shifting)
  );

  rng_state_t       st;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] rnd_q;
  logic             valid_q;
  logic             busy_q;
  logic             work_ge;

  assign work_ge   = (OUT_SPAN != 0) && ({1'b0, work} >= SPAN_X);
  assign bus.rnd   = rnd_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

  // request FSM: decorrelate by SHIFTS real shifts, then reduce by repeated subtraction
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st      <= ST_IDLE;
      cnt     <= '0;
      work    <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (bus.req) begin
            st     <= ST_SHIFT;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (seed_load) begin
            cnt <= '0;
          end else if (shifting) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              work <= lfsr_next;
              st   <= ST_REDUCE;
            end
          end
        end
        ST_REDUCE: begin
          if (work_ge) begin
            work <= work - SPAN_W;
          end else begin
            rnd_q   <= MIN_W + work;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            st      <= ST_IDLE;
          end
        end
        default: begin
          st     <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng.sv
// tb/tb_lfsr_rng.sv - self-checking bench for lfsr_rng
module tb_lfsr_rng;

  localparam logic [7:0] SEED = 8'h64;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       en  [4];
  logic       sl  [4];
  logic [7:0] sin [4];
  logic [7:0] lf  [4];
  logic       rq  [4];
  logic       bz  [4];
  logic       vd  [4];
  logic [7:0] rr  [4];
  logic [7:0] m   [4];
  logic [7:0] tp  [4];
  int         sh  [4];
  int         mn  [4];
  int         sp  [4];

  int n_tests = 0;
  int n_fail  = 0;

  lfsr_rng_if #(.WIDTH(8)) bus_a ();
  lfsr_rng_if #(.WIDTH(8)) bus_b ();
  lfsr_rng_if #(.WIDTH(8)) bus_c ();
  lfsr_rng_if #(.WIDTH(8)) bus_d ();

  assign bus_a.req = rq[0];
  assign bus_b.req = rq[1];
  assign bus_c.req = rq[2];
  assign bus_d.req = rq[3];
  assign bz[0] = bus_a.busy;  assign vd[0] = bus_a.valid;  assign rr[0] = bus_a.rnd;
  assign bz[1] = bus_b.busy;  assign vd[1] = bus_b.valid;  assign rr[1] = bus_b.rnd;
  assign bz[2] = bus_c.busy;  assign vd[2] = bus_c.valid;  assign rr[2] = bus_c.rnd;
  assign bz[3] = bus_d.busy;  assign vd[3] = bus_d.valid;  assign rr[3] = bus_d.rnd;

  lfsr_rng #(.WIDTH(8), .SHIFTS(2), .OUT_MIN(10), .OUT_SPAN(16)) dut_a (
    .clock(clock), .reset(reset), .enable(en[0]), .seed_load(sl[0]),
    .seed_in(sin[0]), .lfsr(lf[0]), .bus(bus_a.slave));
  lfsr_rng #(.WIDTH(8)) dut_b (
    .clock(clock), .reset(reset), .enable(en[1]), .seed_load(sl[1]),
    .seed_in(sin[1]), .lfsr(lf[1]), .bus(bus_b.slave));
  lfsr_rng #(.WIDTH(8), .SHIFTS(8), .OUT_MIN(20), .OUT_SPAN(10)) dut_c (
    .clock(clock), .reset(reset), .enable(en[2]), .seed_load(sl[2]),
    .seed_in(sin[2]), .lfsr(lf[2]), .bus(bus_c.slave));
  lfsr_rng #(.WIDTH(8), .TAPS(8'h00)) dut_d (
    .clock(clock), .reset(reset), .enable(en[3]), .seed_load(sl[3]),
    .seed_in(sin[3]), .lfsr(lf[3]), .bus(bus_d.slave));

  function automatic logic [7:0] lstep(input logic [7:0] s, input logic [7:0] t);
    int ones;
    ones = $countones(s & t);
    return 8'((int'(s) * 2 + ones % 2) % 256);
  endfunction

  function automatic logic [7:0] mnext(input logic [7:0] s, input logic [7:0] t,
                                       input logic e, input logic l, input logic [7:0] si);
    if (l) return (si == 8'h00) ? SEED : si;
    if (s == 8'h00) return SEED;
    if (e) return lstep(s, t);
    return s;
  endfunction

  function automatic logic [7:0] adv(input logic [7:0] s, input logic [7:0] t, input int n);
    logic [7:0] v;
    v = s;
    for (int k = 0; k < n; k++) v = lstep(v, t);
    return v;
  endfunction

  function automatic logic [7:0] exp_rnd(input int i, input logic [7:0] cap);
    if (sp[i] == 0) return 8'((mn[i] + int'(cap)) % 256);
    return 8'((mn[i] + int'(cap) % sp[i]) % 256);
  endfunction

  function automatic int exp_lat(input int i, input logic [7:0] cap);
    if (sp[i] == 0) return sh[i] + 1;
    return sh[i] + int'(cap) / sp[i] + 1;
  endfunction

  task automatic tick();
    @(posedge clock);
    for (int i = 0; i < 4; i++)
      m[i] = reset ? mnext(m[i], tp[i], en[i], sl[i], sin[i]) : SEED;
    #1;
  endtask

  task automatic wait_valid(input int i, input int bound, output int lat,
                            output logic [7:0] r, output int bc);
    lat = 0; bc = 0; r = 8'h00;
    while (lat < bound) begin
      tick();
      lat++;
      if (bz[i]) bc++;
      if (vd[i]) begin
        r = rr[i];
        return;
      end
    end
    lat = -1;
  endtask

  task automatic test_reset();
    logic [7:0] seq [4];
    seq = '{8'h64, 8'hC9, 8'h92, 8'h24};
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en[i] = 1'b0; sl[i] = 1'b0; sin[i] = 8'h00; rq[i] = 1'b0; m[i] = SEED;
    end
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (lf[i] !== SEED || rr[i] !== 8'h00 || vd[i] !== 1'b0 || bz[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: lfsr=%h rnd=%h valid=%b busy=%b, required lfsr=64 rnd=00 valid=0 busy=0",
                 i, lf[i], rr[i], vd[i], bz[i]);
      end
    end
    reset = 1'b1;
    en[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (lf[1] !== seq[k] || lf[1] !== m[1] || vd[1] !== 1'b0 || rr[1] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_seq[%0d]: lfsr=%h valid=%b rnd=%h, required lfsr=%h valid=0 rnd=00",
                 k, lf[1], vd[1], rr[1], seq[k]);
      end
      tick();
    end
  endtask

  task automatic test_directed();
    int lat, bc;
    logic [7:0] r;
    en[0] = 1'b1;
    n_tests++;
    if (lf[0] !== 8'h64) begin
      n_fail++;
      $display("FAIL directed_start: lfsr=%h, required 64", lf[0]);
    end
    rq[0] = 1'b1;
    tick();
    rq[0] = 1'b0;
    n_tests++;
    if (bz[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL directed_busy_e0: busy=%b, required 1", bz[0]);
    end
    wait_valid(0, 60, lat, r, bc);
    n_tests++;
    if (lat !== 5 || r !== 8'd14 || bc !== 4) begin
      n_fail++;
      $display("FAIL directed_sample: latency=%0d rnd=%0d busy_after=%0d, required latency=5 rnd=14 busy_after=4",
               lat, r, bc);
    end
    tick();
    n_tests++;
    if (vd[0] !== 1'b0 || rr[0] !== 8'd14 || bz[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL directed_hold: valid=%b rnd=%0d busy=%b, required valid=0 rnd=14 busy=0",
               vd[0], rr[0], bz[0]);
    end
  endtask

  task automatic test_req_ignored();
    logic [7:0] cap, er, first_r;
    int el, nv, first_k;
    cap = adv(m[0], tp[0], sh[0] + 1);
    er  = exp_rnd(0, cap);
    el  = exp_lat(0, cap);
    rq[0] = 1'b1;
    tick();
    nv = 0; first_k = -1; first_r = 8'h00;
    for (int k = 1; k <= el + 8; k++) begin
      rq[0] = (k == 1 || k == el - 1 || k == el);
      tick();
      if (vd[0]) begin
        nv++;
        if (first_k < 0) begin
          first_k = k; first_r = rr[0];
        end
      end
    end
    rq[0] = 1'b0;
    n_tests++;
    if (nv !== 1 || first_k !== el || first_r !== er || bz[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL req_ignored: valids=%0d at=%0d rnd=%0d busy=%b, required valids=1 at=%0d rnd=%0d busy=0",
               nv, first_k, first_r, bz[0], el, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cap1, cap2, r1, r2;
    int lat1, lat2, bc;
    cap1 = adv(m[0], tp[0], sh[0] + 1);
    rq[0] = 1'b1;
    tick();
    wait_valid(0, 60, lat1, r1, bc);
    n_tests++;
    if (lat1 !== exp_lat(0, cap1) || r1 !== exp_rnd(0, cap1)) begin
      n_fail++;
      $display("FAIL b2b_first: latency=%0d rnd=%0d, required latency=%0d rnd=%0d",
               lat1, r1, exp_lat(0, cap1), exp_rnd(0, cap1));
    end
    cap2 = adv(m[0], tp[0], sh[0] + 1);
    tick();
    rq[0] = 1'b0;
    n_tests++;
    if (bz[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b, required 1", bz[0]);
    end
    wait_valid(0, 60, lat2, r2, bc);
    n_tests++;
    if (lat2 !== exp_lat(0, cap2) || r2 !== exp_rnd(0, cap2)) begin
      n_fail++;
      $display("FAIL b2b_second: latency=%0d rnd=%0d, required latency=%0d rnd=%0d",
               lat2, r2, exp_lat(0, cap2), exp_rnd(0, cap2));
    end
  endtask

  task automatic test_enable_stall();
    logic [7:0] cap, r, held;
    int lat, bc;
    cap = adv(m[0], tp[0], sh[0] + 1);
    rq[0] = 1'b1;
    tick();
    rq[0] = 1'b0;
    en[0] = 1'b0;
    held = m[0];
    tick(); tick(); tick();
    n_tests++;
    if (lf[0] !== held || bz[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold: lfsr=%h busy=%b, required lfsr=%h busy=1", lf[0], bz[0], held);
    end
    en[0] = 1'b1;
    wait_valid(0, 60, lat, r, bc);
    n_tests++;
    if (lat + 3 !== exp_lat(0, cap) + 3 || r !== exp_rnd(0, cap)) begin
      n_fail++;
      $display("FAIL stall_sample: edges_after_accept=%0d rnd=%0d, required edges=%0d rnd=%0d",
               lat + 3, r, exp_lat(0, cap) + 3, exp_rnd(0, cap));
    end
  endtask

  task automatic test_reset_reduce();
    int nv;
    rq[0] = 1'b1;
    tick();
    rq[0] = 1'b0;
    tick(); tick();
    n_tests++;
    if (bz[0] !== 1'b1 || vd[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reduce_entry: busy=%b valid=%b, required busy=1 valid=0", bz[0], vd[0]);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m[i] = SEED;
    #1;
    n_tests++;
    if (rr[0] !== 8'h00 || vd[0] !== 1'b0 || bz[0] !== 1'b0 || lf[0] !== SEED) begin
      n_fail++;
      $display("FAIL reset_in_reduce: rnd=%h valid=%b busy=%b lfsr=%h, required 00 0 0 64",
               rr[0], vd[0], bz[0], lf[0]);
    end
    tick(); tick();
    reset = 1'b1;
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (vd[0]) nv++;
    end
    n_tests++;
    if (nv !== 0 || lf[0] !== m[0]) begin
      n_fail++;
      $display("FAIL reset_abort: valids=%0d lfsr=%h, required valids=0 lfsr=%h", nv, lf[0], m[0]);
    end
  endtask

  task automatic test_seed_load();
    logic [7:0] cap, r;
    int lat, bc;
    sl[0] = 1'b1; sin[0] = 8'h00;
    tick();
    sl[0] = 1'b0;
    n_tests++;
    if (lf[0] !== 8'h64) begin
      n_fail++;
      $display("FAIL seed_zero: lfsr=%h, required 64", lf[0]);
    end
    sl[0] = 1'b1; sin[0] = 8'h5A;
    tick();
    sl[0] = 1'b0;
    n_tests++;
    if (lf[0] !== 8'h5A) begin
      n_fail++;
      $display("FAIL seed_value: lfsr=%h, required 5a", lf[0]);
    end
    rq[0] = 1'b1;
    tick();
    rq[0] = 1'b0;
    sl[0] = 1'b1; sin[0] = 8'h33;
    tick();
    sl[0] = 1'b0;
    cap = adv(8'h33, tp[0], sh[0]);
    wait_valid(0, 60, lat, r, bc);
    n_tests++;
    if (lat !== exp_lat(0, cap) || r !== exp_rnd(0, cap)) begin
      n_fail++;
      $display("FAIL seed_in_shift: latency=%0d rnd=%0d, required latency=%0d rnd=%0d",
               lat, r, exp_lat(0, cap), exp_rnd(0, cap));
    end
  endtask

  task automatic test_lockup();
    logic [7:0] seq [8];
    seq = '{8'hC8, 8'h90, 8'h20, 8'h40, 8'h80, 8'h00, 8'h64, 8'hC8};
    en[3] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_tests++;
      if (lf[3] !== seq[k] || lf[3] !== m[3]) begin
        n_fail++;
        $display("FAIL lockup[%0d]: lfsr=%h, required %h", k, lf[3], seq[k]);
      end
    end
    en[3] = 1'b0;
  endtask

  task automatic test_random(input int i);
    logic [7:0] cap, er, r;
    int el, lat, bc, lo, hi;
    en[i] = 1'b1;
    lo = mn[i];
    hi = (sp[i] == 0) ? 255 : mn[i] + sp[i] - 1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      cap = adv(m[i], tp[i], sh[i] + 1);
      er  = exp_rnd(i, cap);
      el  = exp_lat(i, cap);
      rq[i] = 1'b1;
      tick();
      rq[i] = 1'b0;
      wait_valid(i, 100, lat, r, bc);
      n_tests++;
      if (lat !== el || r !== er || int'(r) < lo || int'(r) > hi) begin
        n_fail++;
        $display("FAIL random[%0d] #%0d: latency=%0d rnd=%0d, required latency=%0d rnd=%0d in %0d..%0d",
                 i, n, lat, r, el, er, lo, hi);
      end
      if (n % 100 == 0) begin
        n_tests++;
        if (lf[i] !== m[i]) begin
          n_fail++;
          $display("FAIL random_lfsr[%0d] #%0d: lfsr=%h, required %h", i, n, lf[i], m[i]);
        end
      end
    end
    en[i] = 1'b0;
  endtask

  initial begin
    tp = '{8'hB8, 8'hB8, 8'hB8, 8'h00};
    sh = '{2, 8, 8, 8};
    mn = '{10, 0, 20, 0};
    sp = '{16, 0, 10, 0};
    test_reset();
    test_directed();
    test_req_ignored();
    test_back_to_back();
    test_enable_stall();
    test_reset_reduce();
    test_seed_load();
    test_lockup();
    test_random(1);
    test_random(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
